// File: rtl/mem_preload_pkg.sv
// Shared constants for the memory preload engine: record command bytes,
// FSM state encoding and error codes.
package mem_preload_pkg;

    localparam logic [7:0] CMD_ADDR = 8'h40;
    localparam logic [7:0] CMD_DATA = 8'h44;
    localparam logic [7:0] CMD_END  = 8'h45;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] S_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] S_CMD       = 3'd1;
    localparam logic [ST_W-1:0] S_ADDR      = 3'd2;
    localparam logic [ST_W-1:0] S_LEN       = 3'd3;
    localparam logic [ST_W-1:0] S_DATA      = 3'd4;
    localparam logic [ST_W-1:0] S_FLUSH_END = 3'd5;
    localparam logic [ST_W-1:0] S_DONE      = 3'd6;
    localparam logic [ST_W-1:0] S_ERR       = 3'd7;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BAD_CMD   = 2'd1;
    localparam logic [1:0] ERR_RSVD_DONE = 2'd2;
    localparam logic [1:0] ERR_RSVD      = 2'd3;

    // A load is in progress in every state except the three resting ones.
    function automatic logic is_busy(input logic [ST_W-1:0] st);
        return !((st == S_IDLE) || (st == S_DONE) || (st == S_ERR));
    endfunction

endpackage

// File: rtl/preload_word_packer.sv
// Accumulates stream bytes into one DATA_W word with per-lane byte enables;
// lane-to-bit mapping follows BIG_ENDIAN.
module preload_word_packer #(
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1,
    localparam int unsigned LANES     = DATA_W / 8,
    localparam int unsigned LB        = $clog2(LANES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [LB-1:0]     lane_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] data_o,
    output logic [LANES-1:0]  be_o,
    output logic              full_c_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [LANES-1:0]  be_q, be_d;
    logic [LB-1:0]     slot_c;

    // Big-endian puts lane offset 0 in the most significant byte.
    always_comb begin
        data_d = data_q;
        be_d   = be_q;
        slot_c = BIG_ENDIAN ? (LB'(LANES - 1) - lane_i) : lane_i;
        if (clr_i) begin
            data_d = '0;
            be_d   = '0;
        end else if (wr_i) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (LB'(i) == slot_c) begin
                    data_d[i*8 +: 8] = byte_i;
                    be_d[i]          = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            be_q   <= '0;
        end else begin
            data_q <= data_d;
            be_q   <= be_d;
        end
    end

    assign data_o   = data_q;
    assign be_o     = be_q;
    assign full_c_o = (lane_i == LB'(LANES - 1));

endmodule

// File: rtl/mem_preload_engine.sv
// Parses an address/data/end record byte stream and issues lane-aligned
// memory writes with byte enables over a valid/ready port.
module mem_preload_engine
    import mem_preload_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1,
    localparam int unsigned LANES     = DATA_W / 8,
    localparam int unsigned LB        = $clog2(LANES),
    localparam int unsigned ABYTES    = (ADDR_W + 7) / 8,
    localparam int unsigned CNT_W     = $clog2(ABYTES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              wr_valid_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [LANES-1:0]  wr_be_o,
    input  logic              wr_ready_i,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       word_count_o
);

    logic [ST_W-1:0]   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        len_q, len_d;
    logic              pend_q, pend_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        ecode_q, ecode_d;
    logic [15:0]       wcnt_q, wcnt_d;

    logic              accept_c, hs_c, pk_clr_c, pk_wr_c, pk_full_c;
    logic [DATA_W-1:0] pk_data;
    logic [LANES-1:0]  pk_be;

    preload_word_packer #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (pk_clr_c),
        .wr_i     (pk_wr_c),
        .lane_i   (addr_q[LB-1:0]),
        .byte_i   (in_data_i),
        .data_o   (pk_data),
        .be_o     (pk_be),
        .full_c_o (pk_full_c)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        waddr_d  = waddr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        pend_d   = pend_q;
        done_d   = done_q;
        err_d    = err_q;
        ecode_d  = ecode_q;
        wcnt_d   = wcnt_q;
        pk_clr_c = 1'b0;
        pk_wr_c  = 1'b0;
        accept_c = in_valid_i & in_ready_q;
        hs_c     = pend_q & wr_ready_i;

        // The packed word is the write payload, so it empties on handshake.
        if (hs_c) begin
            pend_d   = 1'b0;
            pk_clr_c = 1'b1;
            if (wcnt_q != 16'hFFFF) begin
                wcnt_d = wcnt_q + 16'd1;
            end
        end

        case (state_q)
            S_CMD: begin
                if (accept_c) begin
                    case (in_data_i)
                        CMD_ADDR: begin
                            state_d = S_ADDR;
                            cnt_d   = '0;
                            pend_d  = |pk_be;
                        end
                        CMD_DATA: state_d = S_LEN;
                        CMD_END: begin
                            if (|pk_be) begin
                                pend_d  = 1'b1;
                                state_d = S_FLUSH_END;
                            end else begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                            ecode_d = ERR_BAD_CMD;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (accept_c) begin
                    addr_d = ADDR_W'({addr_q, in_data_i});
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ABYTES - 1)) begin
                        state_d = S_CMD;
                    end
                end
            end
            S_LEN: begin
                if (accept_c) begin
                    len_d   = in_data_i;
                    state_d = (in_data_i == 8'd0) ? S_CMD : S_DATA;
                end
            end
            S_DATA: begin
                // The top lane always closes a word, including at address wrap.
                if (accept_c) begin
                    pk_wr_c = 1'b1;
                    waddr_d = {addr_q[ADDR_W-1:LB], LB'(0)};
                    addr_d  = addr_q + ADDR_W'(1);
                    pend_d  = pk_full_c;
                    len_d   = len_q - 8'd1;
                    if (len_q == 8'd1) begin
                        state_d = S_CMD;
                    end
                end
            end
            S_FLUSH_END: begin
                if (hs_c) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (start_i) begin
                    state_d  = S_CMD;
                    addr_d   = '0;
                    cnt_d    = '0;
                    pk_clr_c = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    ecode_d  = ERR_NONE;
                    wcnt_d   = '0;
                end
            end
        endcase

        busy_d     = is_busy(state_d);
        in_ready_d = is_busy(state_d) && (state_d != S_FLUSH_END) && !pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            waddr_q    <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            pend_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ecode_q    <= ERR_NONE;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            waddr_q    <= waddr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            pend_q     <= pend_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ecode_q    <= ecode_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign wr_valid_o   = pend_q;
    assign wr_addr_o    = waddr_q;
    assign wr_data_o    = pk_data;
    assign wr_be_o      = pk_be;
    assign busy_o       = busy_q;
    assign load_done_o  = done_q;
    assign err_o        = err_q;
    assign err_code_o   = ecode_q;
    assign word_count_o = wcnt_q;

endmodule

// File: tb/tb_mem_preload_engine.sv
// Directed bench for mem_preload_engine: a 32-bit big-endian and a 64-bit
// little-endian instance share one stream; a scoreboard checks every write.
module tb_mem_preload_engine;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start32, start64, in_valid, wr_ready;
    logic [7:0] in_data;

    logic        ir32, wv32, busy32, done32, err32;
    logic [31:0] wa32, wd32;
    logic [3:0]  wb32;
    logic [1:0]  ec32;
    logic [15:0] wc32;

    logic        ir64, wv64, busy64, done64, err64;
    logic [31:0] wa64;
    logic [63:0] wd64;
    logic [7:0]  wb64;
    logic [1:0]  ec64;
    logic [15:0] wc64;

    logic        sel;
    logic        ir, wv, busy, done, err;
    logic [31:0] wa;
    logic [63:0] wd;
    logic [7:0]  wb;
    logic [1:0]  ec;
    logic [15:0] wc;

    int   checks = 0;
    int   errors = 0;
    int   last_wait;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [7:0] seq[$];

    always #5 clk = ~clk;

    mem_preload_engine #(.ADDR_W(32), .DATA_W(32), .BIG_ENDIAN(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .start_i(start32), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(ir32), .wr_valid_o(wv32), .wr_addr_o(wa32),
        .wr_data_o(wd32), .wr_be_o(wb32), .wr_ready_i(wr_ready), .busy_o(busy32),
        .load_done_o(done32), .err_o(err32), .err_code_o(ec32), .word_count_o(wc32)
    );

    mem_preload_engine #(.ADDR_W(32), .DATA_W(64), .BIG_ENDIAN(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n), .start_i(start64), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(ir64), .wr_valid_o(wv64), .wr_addr_o(wa64),
        .wr_data_o(wd64), .wr_be_o(wb64), .wr_ready_i(wr_ready), .busy_o(busy64),
        .load_done_o(done64), .err_o(err64), .err_code_o(ec64), .word_count_o(wc64)
    );

    always_comb begin
        ir   = sel ? ir64   : ir32;
        wv   = sel ? wv64   : wv32;
        busy = sel ? busy64 : busy32;
        done = sel ? done64 : done32;
        err  = sel ? err64  : err32;
        wa   = sel ? wa64   : wa32;
        wd   = sel ? wd64   : {32'd0, wd32};
        wb   = sel ? wb64   : {4'd0, wb32};
        ec   = sel ? ec64   : ec32;
        wc   = sel ? wc64   : wc32;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Every accepted write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n && wv && wr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write got addr %0h exp none", wa);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(wa), 64'(mon_e.addr));
                chk("wr_data", wd, mon_e.data);
                chk("wr_be", 64'(wb), 64'(mon_e.be));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [63:0] d, input logic [7:0] b);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.be   = b;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        if (sel) start64 = 1'b1;
        else     start32 = 1'b1;
        tick();
        start32 = 1'b0;
        start64 = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!ir && n <= 100) begin
            n++;
            @(negedge clk);
        end
        last_wait = n;
        if (n > 100) begin
            checks++;
            errors++;
            $error("FAIL in_ready_timeout got 0 exp 1 byte %0h", b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic wait_done(input int exp_wc);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("load_done", 64'(done), 64'd1);
        chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
        chk("word_count", 64'(wc), 64'(exp_wc));
        chk("busy_after_done", 64'(busy), 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; start32 = 1'b0; start64 = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; wr_ready = 1'b1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_valid", 64'(wv), 64'd0);
        chk("rst_in_ready", 64'(ir), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'({err, ec}), 64'd0);
        chk("rst_word_count", 64'(wc), 64'd0);
        chk("rst_wr_payload", 64'(wa) | wd | 64'(wb), 64'd0);
        chk("rst_dut64", 64'({wv64, ir64, busy64}) | wd64, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // T1: aligned word, big-endian
        pulse_start();
        chk("busy_in_cmd", 64'(busy), 64'd1);
        push(32'h100, 64'h11223344, 8'hF);
        seq = '{8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h44, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_seq();
        wait_done(1);

        // T2: unaligned start, partial word flushed by E
        pulse_start();
        chk("start_clears_done", 64'(done), 64'd0);
        chk("start_clears_count", 64'(wc), 64'd0);
        push(32'h100, 64'h0000AABB, 8'h3);
        push(32'h104, 64'hCC000000, 8'h8);
        seq = '{8'h40, 8'h00, 8'h00, 8'h01, 8'h02, 8'h44, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h45};
        send_seq();
        wait_done(2);

        // T3: write backpressure holds payload and stalls the stream
        pulse_start();
        wr_ready = 1'b0;
        push(32'h100, 64'h11223344, 8'hF);
        seq = '{8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h44, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq();
        repeat (5) begin
            @(negedge clk);
            chk("stall_wr_valid", 64'(wv), 64'd1);
            chk("stall_wr_addr", 64'(wa), 64'h100);
            chk("stall_wr_data", wd, 64'h11223344);
            chk("stall_wr_be", 64'(wb), 64'hF);
            chk("stall_in_ready", 64'(ir), 64'd0);
        end
        tick();
        wr_ready = 1'b1;
        send_byte(8'h45);
        chk("resume_latency", 64'(last_wait), 64'd1);
        wait_done(1);

        // T4: split data records, start ignored while busy, E after new address
        pulse_start();
        push(32'h0, 64'h01020304, 8'hF);
        seq = '{8'h44, 8'h02, 8'h01, 8'h02};
        send_seq();
        pulse_start();
        chk("start_ignored_busy", 64'(busy), 64'd1);
        seq = '{8'h44, 8'h02, 8'h03, 8'h04};
        send_seq();
        push(32'h200, 64'h55000000, 8'h8);
        seq = '{8'h40, 8'h00, 8'h00, 8'h02, 8'h00, 8'h44, 8'h01, 8'h55, 8'h45};
        send_seq();
        wait_done(2);

        // T4b: partial word flushed by a new address record
        pulse_start();
        push(32'h0, 64'h77000000, 8'h8);
        push(32'h300, 64'h88000000, 8'h8);
        seq = '{8'h44, 8'h01, 8'h77, 8'h40, 8'h00, 8'h00, 8'h03, 8'h00, 8'h44, 8'h01, 8'h88, 8'h45};
        send_seq();
        wait_done(2);

        // T4c: E right after @ issues no write
        pulse_start();
        seq = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h10, 8'h45};
        send_seq();
        wait_done(0);

        // T5: unknown command, recovery by start, reset mid-load
        pulse_start();
        send_byte(8'h7F);
        @(negedge clk);
        chk("err_flag", 64'(err), 64'd1);
        chk("err_code", 64'(ec), 64'd1);
        chk("err_in_ready", 64'(ir), 64'd0);
        chk("err_no_write", 64'(wv), 64'd0);
        chk("err_busy", 64'(busy), 64'd0);
        tick();
        pulse_start();
        chk("restart_err", 64'(err), 64'd0);
        chk("restart_err_code", 64'(ec), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        push(32'h100, 64'h11223344, 8'hF);
        seq = '{8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h44, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_seq();
        wait_done(1);

        pulse_start();
        wr_ready = 1'b0;
        seq = '{8'h40, 8'h00, 8'h00, 8'h04, 8'h00, 8'h44, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        send_seq();
        @(negedge clk);
        chk("pre_reset_pending", 64'(wv), 64'd1);
        chk("pre_reset_addr", 64'(wa), 64'h400);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_valid", 64'(wv), 64'd0);
        chk("async_rst_payload", 64'(wa) | wd | 64'(wb), 64'd0);
        chk("async_rst_flags", 64'({busy, ir, done, err}), 64'd0);
        tick();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        tick();

        // T6: 64-bit little-endian, then address wrap
        sel = 1'b1;
        pulse_start();
        push(32'h8, 64'h0000000000A3A2A1, 8'h07);
        seq = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h08, 8'h44, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'h45};
        send_seq();
        wait_done(1);

        pulse_start();
        push(32'hFFFFFFF8, 64'hB2B1000000000000, 8'hC0);
        push(32'h0, 64'h00000000000000B3, 8'h01);
        seq = '{8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h44, 8'h03, 8'hB1, 8'hB2, 8'hB3, 8'h45};
        send_seq();
        wait_done(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
